// File: rtl/alu_rr_sched_pkg.sv
// Shared definitions for the round-robin ALU scheduler: opcodes, FSM states, requester count.
package alu_rr_sched_pkg;

    localparam int NUM_REQ = 2;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_rr_sched_alu_core.sv
// Combinational ALU datapath shared by both requesters; undefined opcodes flag err and yield 0.
module alu_core
    import alu_rr_sched_pkg::*;
#(
    parameter int DATA_W = 3
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              err
);

    logic shift_oob;

    // Shift amounts use the whole of b, so anything past the width clears the result.
    assign shift_oob = ({1'b0, b} >= (DATA_W + 1)'(DATA_W));

    always_comb begin
        result = '0;
        err    = 1'b0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_SLL:  result = shift_oob ? '0 : (a << b);
            OP_XOR:  result = a ^ b;
            OP_SRL:  result = shift_oob ? '0 : (a >> b);
            OP_SLT:  result[0] = ($signed(a) < $signed(b));
            OP_SLTU: result[0] = (a < b);
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_rr_sched.sv
// Two-requester round-robin ALU scheduler with IDLE/EXEC/RESP handshake FSM.
// Define ALU_RR_SCHED_CNT_EN to add per-requester grant counters gnt_cnt0/gnt_cnt1.
module alu_rr_sched
    import alu_rr_sched_pkg::*;
#(
    parameter int DATA_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic [3:0]         req0_op,
    input  logic [DATA_W-1:0]  req0_a,
    input  logic [DATA_W-1:0]  req0_b,
    input  logic [3:0]         req1_op,
    input  logic [DATA_W-1:0]  req1_a,
    input  logic [DATA_W-1:0]  req1_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_data,
    output logic               rsp_id,
    output logic               rsp_err,
    output logic               busy
`ifdef ALU_RR_SCHED_CNT_EN
    ,
    output logic [CNT_W-1:0]   gnt_cnt0,
    output logic [CNT_W-1:0]   gnt_cnt1
`endif
);

    state_t            state;
    logic              last;
    logic              gnt_id;
    logic              accept;
    logic [3:0]        sel_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [3:0]        cap_op;
    logic [DATA_W-1:0] cap_a;
    logic [DATA_W-1:0] cap_b;
    logic              cap_id;
    logic [DATA_W-1:0] alu_result;
    logic              alu_err;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        gnt_id = 1'b0;
        if (&req_valid) begin
            gnt_id = ~last;
        end else if (req_valid[1]) begin
            gnt_id = 1'b1;
        end
        req_ready = '0;
        if (state == IDLE && |req_valid) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign accept = |(req_valid & req_ready);
    assign sel_op = gnt_id ? req1_op : req0_op;
    assign sel_a  = gnt_id ? req1_a  : req0_a;
    assign sel_b  = gnt_id ? req1_b  : req0_b;
    assign busy   = (state != IDLE);

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu_core (
        .op     (cap_op),
        .a      (cap_a),
        .b      (cap_b),
        .result (alu_result),
        .err    (alu_err)
    );

    // The result lands in the output registers during EXEC; rsp_valid follows one cycle into RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            cap_op    <= '0;
            cap_a     <= '0;
            cap_b     <= '0;
            cap_id    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_op <= sel_op;
                        cap_a  <= sel_a;
                        cap_b  <= sel_b;
                        cap_id <= gnt_id;
                        last   <= gnt_id;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data <= alu_result;
                    rsp_err  <= alu_err;
                    rsp_id   <= cap_id;
                    state    <= RESP;
                end
                RESP: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_RR_SCHED_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else if (accept) begin
            if (gnt_id) begin
                gnt_cnt1 <= gnt_cnt1 + 1'b1;
            end else begin
                gnt_cnt0 <= gnt_cnt0 + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_rr_sched.sv
// Self-checking bench for alu_rr_sched: directed scenarios plus randomized traffic against a behavioural model.
module tb_alu_rr_sched;

    localparam int DW  = 3;
    localparam int CW  = 8;
    localparam int MOD = 1 << DW;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [3:0]    req0_op, req1_op;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_id, rsp_err, busy;
`ifdef ALU_RR_SCHED_CNT_EN
    logic [CW-1:0] gnt_cnt0, gnt_cnt1;
`endif

    int checks = 0;
    int errors = 0;
    int model_last = 1;
    int model_cnt[2];

    always #5 clk = ~clk;

    alu_rr_sched #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_op   (req0_op),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req1_op   (req1_op),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .busy      (busy)
`ifdef ALU_RR_SCHED_CNT_EN
        ,
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1)
`endif
    );

    // Arithmetic reference: values as plain integers, signedness by explicit offset.
    function automatic int ref_alu(input int op, input int a, input int b, output bit err);
        int sa, sb;
        sa  = (a >= MOD / 2) ? a - MOD : a;
        sb  = (b >= MOD / 2) ? b - MOD : b;
        err = 1'b0;
        case (op)
            0: return (a + b) % MOD;
            1: return (a - b + MOD) % MOD;
            2: return a & b;
            3: return a | b;
            4: return (b >= DW) ? 0 : (a * (1 << b)) % MOD;
            5: return a ^ b;
            6: return (b >= DW) ? 0 : a / (1 << b);
            7: return (sa < sb) ? 1 : 0;
            8: return (a < b) ? 1 : 0;
            default: begin
                err = 1'b1;
                return 0;
            end
        endcase
    endfunction

    function automatic int model_pick(input logic [1:0] v);
        if (v == 2'b11) return 1 - model_last;
        if (v[1]) return 1;
        return 0;
    endfunction

    function automatic void model_accept(input int g);
        model_last = g;
        model_cnt[g] = model_cnt[g] + 1;
    endfunction

    // Drives one request, waits for its response and completes the handshake after 'stall' extra cycles.
    task automatic send(input logic [1:0] v, input int op0, input int a0, input int b0,
                        input int op1, input int a1, input int b1, input int stall,
                        output bit ok, output int gid, output int lat,
                        output int data, output int id, output bit err);
        int n;
        @(negedge clk);
        req_valid = v;
        req0_op = 4'(op0); req0_a = DW'(a0); req0_b = DW'(b0);
        req1_op = 4'(op1); req1_a = DW'(a1); req1_b = DW'(b1);
        rsp_ready = (stall == 0);
        #1;
        n = 0;
        while ((req_valid & req_ready) == 2'b00 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        ok  = (n < 20);
        gid = req_ready[1] ? 1 : 0;
        if (!ok) begin
            req_valid = 2'b00;
            lat = -1; data = -1; id = -1; err = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        data = int'(rsp_data);
        id   = rsp_id ? 1 : 0;
        err  = rsp_err;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b00; rsp_ready = 1'b1;
        req0_op = '0; req0_a = '0; req0_b = '0;
        req1_op = '0; req1_a = '0; req1_b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_err, busy} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected 0", {rsp_valid, rsp_data, rsp_id, rsp_err, busy});
        end
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("[TB] FAIL reset_tie_ready: got %b expected 01", req_ready);
        end
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("[TB] FAIL reset_single_ready: got %b expected 10", req_ready);
        end
`ifdef ALU_RR_SCHED_CNT_EN
        checks++;
        if (gnt_cnt0 !== '0 || gnt_cnt1 !== '0) begin
            errors++;
            $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", gnt_cnt0, gnt_cnt1);
        end
`endif
        @(negedge clk);
        req_valid = 2'b00;
        rst = 1'b0;
        model_last = 1;
        model_cnt[0] = 0;
        model_cnt[1] = 0;
    endtask

    task automatic test_add();
        bit ok, err, e_err;
        int gid, lat, data, id, e_gid;
        e_gid = model_pick(2'b01);
        send(2'b01, 0, 5, 1, 0, 0, 0, 0, ok, gid, lat, data, id, err);
        model_accept(e_gid);
        checks++;
        if (!ok || gid != e_gid) begin
            errors++;
            $display("[TB] FAIL add_grant: got ok=%0d gid=%0d expected ok=1 gid=%0d", ok, gid, e_gid);
        end
        checks++;
        if (lat != 2) begin
            errors++;
            $display("[TB] FAIL add_latency: got %0d expected 2", lat);
        end
        checks++;
        if (data != 6 || data != ref_alu(0, 5, 1, e_err)) begin
            errors++;
            $display("[TB] FAIL add_data: got %0d expected 6", data);
        end
        checks++;
        if (id != 0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_id_err: got id=%0d err=%0d expected id=0 err=0", id, err);
        end
    endtask

    task automatic test_ops();
        int ops[4] = '{7, 8, 4, 6};
        int bs[4]  = '{1, 1, 4, 1};
        int exp[4] = '{1, 0, 0, 2};
        bit ok, err, e_err;
        int gid, lat, data, id, e_gid, r;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] v;
            v = (i % 2 == 1) ? 2'b10 : 2'b01;
            e_gid = model_pick(v);
            if (v == 2'b10) send(v, 0, 0, 0, ops[i], 5, bs[i], 0, ok, gid, lat, data, id, err);
            else            send(v, ops[i], 5, bs[i], 0, 0, 0, 0, ok, gid, lat, data, id, err);
            model_accept(e_gid);
            r = ref_alu(ops[i], 5, bs[i], e_err);
            checks++;
            if (!ok || data != exp[i] || data != r || err !== 1'b0 || id != e_gid) begin
                errors++;
                $display("[TB] FAIL ops_%0d: got ok=%0d data=%0d err=%0d id=%0d expected data=%0d err=0 id=%0d",
                         ops[i], ok, data, err, id, exp[i], e_gid);
            end
        end
    endtask

    task automatic test_illegal();
        bit ok, err;
        int gid, lat, data, id;
        send(2'b01, 12, 5, 1, 0, 0, 0, 0, ok, gid, lat, data, id, err);
        model_accept(model_pick(2'b01));
        checks++;
        if (!ok || data != 0 || err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL illegal_op: got data=%0d err=%0d expected data=0 err=1", data, err);
        end
        send(2'b01, 0, 7, 1, 0, 0, 0, 0, ok, gid, lat, data, id, err);
        model_accept(model_pick(2'b01));
        checks++;
        if (!ok || data != 0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_wrap: got data=%0d err=%0d expected data=0 err=0", data, err);
        end
    endtask

    task automatic test_back_to_back();
        int g_q[$], g_cyc[$], r_data[$], r_id[$];
        int e_g, e_d, n;
        bit e_err;
        @(negedge clk);
        req0_op = 4'd1; req0_a = DW'(5); req0_b = DW'(1);
        req1_op = 4'd5; req1_a = DW'(5); req1_b = DW'(1);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (r_data.size() >= 4) break;
            #1;
            if ((req_valid & req_ready) != 2'b00) begin
                g_q.push_back(req_ready[1] ? 1 : 0);
                g_cyc.push_back(cyc);
            end
            if (rsp_valid && rsp_ready) begin
                r_data.push_back(int'(rsp_data));
                r_id.push_back(rsp_id ? 1 : 0);
            end
            @(negedge clk);
            if (g_q.size() >= 4) req_valid = 2'b00;
        end
        req_valid = 2'b00;
        checks++;
        if (g_q.size() != 4 || r_data.size() != 4) begin
            errors++;
            $display("[TB] FAIL b2b_count: got grants=%0d rsps=%0d expected 4/4", g_q.size(), r_data.size());
        end
        n = (g_q.size() < r_data.size()) ? g_q.size() : r_data.size();
        for (int i = 0; i < n; i++) begin
            e_g = model_pick(2'b11);
            model_accept(e_g);
            e_d = (e_g == 0) ? ref_alu(1, 5, 1, e_err) : ref_alu(5, 5, 1, e_err);
            checks++;
            if (g_q[i] != e_g || r_data[i] != e_d || r_data[i] != 4 || r_id[i] != e_g) begin
                errors++;
                $display("[TB] FAIL b2b_%0d: got gnt=%0d data=%0d id=%0d expected gnt=%0d data=%0d id=%0d",
                         i, g_q[i], r_data[i], r_id[i], e_g, e_d, e_g);
            end
            if (i > 0) begin
                checks++;
                if (g_cyc[i] - g_cyc[i-1] != 4) begin
                    errors++;
                    $display("[TB] FAIL b2b_spacing_%0d: got %0d expected 4", i, g_cyc[i] - g_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_stall();
        int n, e_g, e_d;
        bit e_err;
        logic [DW+1:0] snap;
        @(negedge clk);
        req0_op = 4'd2; req0_a = DW'(6); req0_b = DW'(3);
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        #1;
        n = 0;
        while (req_ready == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
        e_g = model_pick(2'b01);
        model_accept(e_g);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        n = 0;
        while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        e_d = ref_alu(2, 6, 3, e_err);
        checks++;
        if (!rsp_valid || int'(rsp_data) != e_d || rsp_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_rsp: got valid=%0d data=%0d expected valid=1 data=%0d", rsp_valid, rsp_data, e_d);
        end
        snap = {rsp_data, rsp_id, rsp_err};
        // Requests raised while busy and then withdrawn must leave the pointer alone.
        req_valid = 2'b11;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (!rsp_valid || {rsp_data, rsp_id, rsp_err} !== snap || req_ready !== 2'b00 || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stall_hold_%0d: got valid=%0d out=%b ready=%b busy=%0d expected 1/%b/00/1",
                         c, rsp_valid, {rsp_data, rsp_id, rsp_err}, req_ready, busy, snap);
            end
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_release: got busy=%0d valid=%0d expected 0/0", busy, rsp_valid);
        end
    endtask

    task automatic test_reset_exec();
        bit ok, err, seen;
        int gid, lat, data, id, n;
        @(negedge clk);
        req0_op = 4'd0; req0_a = DW'(3); req0_b = DW'(2);
        req_valid = 2'b01;
        #1;
        n = 0;
        while (req_ready == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
        model_accept(model_pick(2'b01));
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL exec_busy: got %0d expected 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: got busy=%0d valid=%0d expected 0/0", busy, rsp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        model_last = 1;
        model_cnt[0] = 0;
        model_cnt[1] = 0;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("[TB] FAIL reset_discard: got rsp_valid=1 expected 0");
        end
`ifdef ALU_RR_SCHED_CNT_EN
        checks++;
        if (gnt_cnt0 !== '0 || gnt_cnt1 !== '0) begin
            errors++;
            $display("[TB] FAIL reset_exec_counters: got %0d/%0d expected 0/0", gnt_cnt0, gnt_cnt1);
        end
`endif
        send(2'b11, 3, 4, 1, 5, 2, 2, 0, ok, gid, lat, data, id, err);
        model_accept(0);
        checks++;
        if (!ok || gid != 0 || data != 5 || id != 0) begin
            errors++;
            $display("[TB] FAIL reset_tie: got gid=%0d data=%0d id=%0d expected 0/5/0", gid, data, id);
        end
    endtask

    task automatic test_random();
        bit ok, err, e_err;
        int gid, lat, data, id, e_g, e_d;
        int op0, a0, b0, op1, a1, b1, stall;
        logic [1:0] v;
        for (int i = 0; i < 40; i++) begin
            v = 2'($urandom_range(1, 3));
            op0 = $urandom_range(0, 15); a0 = $urandom_range(0, MOD - 1); b0 = $urandom_range(0, MOD - 1);
            op1 = $urandom_range(0, 15); a1 = $urandom_range(0, MOD - 1); b1 = $urandom_range(0, MOD - 1);
            stall = $urandom_range(0, 3);
            e_g = model_pick(v);
            e_d = (e_g == 0) ? ref_alu(op0, a0, b0, e_err) : ref_alu(op1, a1, b1, e_err);
            send(v, op0, a0, b0, op1, a1, b1, stall, ok, gid, lat, data, id, err);
            model_accept(e_g);
            checks++;
            if (!ok || gid != e_g || lat != 2 || data != e_d || id != e_g || err !== e_err) begin
                errors++;
                $display("[TB] FAIL rand_%0d: got ok=%0d gid=%0d lat=%0d data=%0d id=%0d err=%0d expected gid=%0d lat=2 data=%0d err=%0d",
                         i, ok, gid, lat, data, id, err, e_g, e_d, e_err);
            end
        end
`ifdef ALU_RR_SCHED_CNT_EN
        checks++;
        if (int'(gnt_cnt0) != model_cnt[0] % (1 << CW) || int'(gnt_cnt1) != model_cnt[1] % (1 << CW)) begin
            errors++;
            $display("[TB] FAIL counters: got %0d/%0d expected %0d/%0d", gnt_cnt0, gnt_cnt1, model_cnt[0], model_cnt[1]);
        end
`endif
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_add();
        test_ops();
        test_illegal();
        test_back_to_back();
        test_stall();
        test_reset_exec();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
